// File: rtl/instr_encoder_loader.sv
// Encodes instruction field tuples into 32-bit words and streams them through a
// small FIFO into instruction memory, one load session per start pulse.
module instr_encoder_loader #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        in_cond,
  input  logic [1:0]        in_op,
  input  logic [5:0]        in_funct,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [11:0]       in_src2,
  input  logic [23:0]       in_imm24,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         fifo_q [DEPTH];
  logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                err_ill_q, err_ill_d;
  logic                err_ovf_q, err_ovf_d;

  logic        fifo_empty;
  logic        fifo_full;
  logic        cnt_below;
  logic        accept;
  logic        legal;
  logic        push;
  logic        pop;
  logic [31:0] enc_word;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign cnt_below  = (cnt_q < CNT_W'(MAX_WORDS));

  assign in_ready  = (state_q == ST_LOAD) && !fifo_full && cnt_below;
  assign accept    = in_valid && in_ready;
  assign legal     = (in_op != 2'b11);
  assign push      = accept && legal;
  assign pop       = mem_we && mem_ready;

  assign mem_we       = !fifo_empty;
  assign mem_wdata    = fifo_q[rd_ptr_q[PTR_W-1:0]];
  assign mem_addr     = addr_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign err_illegal  = err_ill_q;
  assign err_overflow = err_ovf_q;

  // Branches replace the register/operand fields with the 24-bit offset.
  always_comb begin
    enc_word = {in_cond, in_op, in_funct, in_rn, in_rd, in_src2};
    if (in_op == 2'b10) begin
      enc_word = {in_cond, 2'b10, in_funct[5:4], in_imm24};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    err_ill_d = err_ill_q;
    err_ovf_d = err_ovf_q;
    wr_ptr_d  = wr_ptr_q + (PTR_W + 1)'(push);
    rd_ptr_d  = rd_ptr_q + (PTR_W + 1)'(pop);
    if (pop) begin
      addr_d = addr_q + ADDR_W'(4);
    end
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LOAD;
          cnt_d     = '0;
          err_ill_d = 1'b0;
          err_ovf_d = 1'b0;
          addr_d    = base_addr & ~ADDR_W'(3);
        end
      end
      ST_LOAD: begin
        if (push) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (accept && !legal) begin
          err_ill_d = 1'b1;
        end
        if (accept && in_last) begin
          state_d = ST_FLUSH;
        end
        if (in_valid && !cnt_below) begin
          err_ovf_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (fifo_empty) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      err_ill_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      err_ill_q <= err_ill_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  // Storage is cleared on reset so mem_wdata reads back as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push) begin
      fifo_q[wr_ptr_q[PTR_W-1:0]] <= enc_word;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomised self-checking bench for instr_encoder_loader against a word-list model.
module tb_instr_encoder_loader;

  localparam int unsigned TB_DEPTH = 4;
  localparam int unsigned TB_MAX   = 8;

  typedef struct {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] imm;
    logic        last;
  } tup_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [3:0]  in_cond = '0;
  logic [1:0]  in_op = '0;
  logic [5:0]  in_funct = '0;
  logic [3:0]  in_rn = '0;
  logic [3:0]  in_rd = '0;
  logic [11:0] in_src2 = '0;
  logic [23:0] in_imm24 = '0;
  logic        mem_we;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err_illegal;
  logic        err_overflow;

  logic mem_ready_man = 1'b0;
  logic rnd_mode = 1'b0;
  logic rnd_bit = 1'b1;
  assign mem_ready = rnd_mode ? rnd_bit : mem_ready_man;

  int checks = 0;
  int failures = 0;

  logic [31:0] act_addr[$];
  logic [31:0] act_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];

  instr_encoder_loader #(
    .DEPTH(TB_DEPTH), .ADDR_W(32), .MAX_WORDS(TB_MAX)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_cond(in_cond), .in_op(in_op), .in_funct(in_funct),
    .in_rn(in_rn), .in_rd(in_rd), .in_src2(in_src2), .in_imm24(in_imm24),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .err_illegal(err_illegal), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  // Write monitor plus hold-while-stalled check, sampled mid-cycle.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst_n && prev_stall && mem_we) begin
      checks++;
      if (mem_wdata !== prev_data || mem_addr !== prev_addr) begin
        failures++;
        $display("FAIL stall_hold: got addr=%h data=%h, need addr=%h data=%h",
                 mem_addr, mem_wdata, prev_addr, prev_data);
      end
    end
    if (rst_n && mem_we && mem_ready) begin
      act_addr.push_back(mem_addr);
      act_data.push_back(mem_wdata);
    end
    prev_stall = rst_n && mem_we && !mem_ready;
    prev_addr  = mem_addr;
    prev_data  = mem_wdata;
  end

  function automatic logic [31:0] model_word(input tup_t t);
    logic [31:0] w;
    if (t.op == 2'd2)
      w = (32'(t.cond) << 28) + (32'd2 << 26) + (32'(t.funct / 16) << 24) + 32'(t.imm);
    else
      w = (32'(t.cond) << 28) + (32'(t.op) << 26) + (32'(t.funct) << 20)
        + (32'(t.rn) << 16) + (32'(t.rd) << 12) + 32'(t.src2);
    return w;
  endfunction

  function automatic tup_t rand_tup(input bit allow_illegal, input bit last);
    tup_t t;
    t.cond  = 4'($urandom);
    t.op    = (allow_illegal && $urandom_range(0, 5) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    t.funct = 6'($urandom);
    t.rn    = 4'($urandom);
    t.rd    = 4'($urandom);
    t.src2  = 12'($urandom);
    t.imm   = 24'($urandom);
    t.last  = last;
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic start_session(input logic [31:0] base);
    base_addr = base;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic drive_fields(input tup_t t);
    in_cond = t.cond; in_op = t.op; in_funct = t.funct; in_rn = t.rn;
    in_rd = t.rd; in_src2 = t.src2; in_imm24 = t.imm; in_last = t.last;
  endtask

  // Offers one tuple and returns once it has been accepted (or the budget expires).
  task automatic send_tuple(input tup_t t);
    bit ok = 1'b0;
    drive_fields(t);
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = (in_ready === 1'b1);
      step();
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 for 300 cycles, need accept");
    end
  endtask

  task automatic expect_tuple(input tup_t t, inout logic [31:0] addr);
    if (t.op != 2'd3) begin
      exp_addr.push_back(addr);
      exp_data.push_back(model_word(t));
      addr = addr + 32'd4;
    end
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      seen = (done === 1'b1);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_done: got no done pulse in 500 cycles, need one", tag);
    end else begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL %s_done_width: got done=%b busy=%b, need done=0 busy=0", tag, done, busy);
      end
    end
    step();
  endtask

  task automatic check_writes(input string tag);
    checks++;
    if (act_data.size() != exp_data.size()) begin
      failures++;
      $display("FAIL %s_count: got %0d writes, need %0d", tag, act_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < act_data.size(); i++) begin
      checks++;
      if (act_addr[i] !== exp_addr[i] || act_data[i] !== exp_data[i]) begin
        failures++;
        $display("FAIL %s_word%0d: got %h<=%h, need %h<=%h", tag, i,
                 act_addr[i], act_data[i], exp_addr[i], exp_data[i]);
      end
    end
    act_addr.delete(); act_data.delete(); exp_addr.delete(); exp_data.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    #2;
    checks++;
    if ({in_ready, mem_we, busy, done, err_illegal, err_overflow} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b, need 000000",
               {in_ready, mem_we, busy, done, err_illegal, err_overflow});
    end
    checks++;
    if (mem_wdata !== 32'h0 || mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus: got addr=%h data=%h, need 0/0", mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    tup_t t = '{cond: 4'hE, op: 2'd0, funct: 6'h28, rn: 4'd1, rd: 4'd2,
                src2: 12'h005, imm: 24'h0, last: 1'b1};
    mem_ready_man = 1'b1;
    start_session(32'h100);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL t1_load: got busy=%b in_ready=%b, need 1/1", busy, in_ready);
    end
    send_tuple(t);
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_wdata !== 32'hE2812005 || mem_addr !== 32'h100) begin
      failures++;
      $display("FAIL t1_latency: got we=%b %h<=%h, need 1 00000100<=e2812005",
               mem_we, mem_addr, mem_wdata);
    end
    exp_addr.push_back(32'h100);
    exp_data.push_back(32'hE2812005);
    wait_done("t1");
    check_writes("t1");
  endtask

  task automatic test_branch_illegal();
    tup_t b = '{cond: 4'hE, op: 2'd2, funct: 6'h20, rn: 4'd7, rd: 4'd9,
                src2: 12'hABC, imm: 24'hFFFFFE, last: 1'b0};
    tup_t x = rand_tup(1'b0, 1'b1);
    x.op = 2'd3;
    start_session(32'h0);
    send_tuple(b);
    send_tuple(x);
    exp_addr.push_back(32'h0);
    exp_data.push_back(32'hEAFFFFFE);
    wait_done("t2");
    check_writes("t2");
    checks++;
    if (err_illegal !== 1'b1 || err_overflow !== 1'b0) begin
      failures++;
      $display("FAIL t2_err: got ill=%b ovf=%b, need 1/0", err_illegal, err_overflow);
    end
  endtask

  task automatic test_backpressure();
    tup_t t[6];
    logic [31:0] a = 32'h200;
    int stall_ok = 1;
    for (int i = 0; i < 6; i++) t[i] = rand_tup(1'b0, i == 5);
    mem_ready_man = 1'b0;
    start_session(32'h200);
    checks++;
    if (err_illegal !== 1'b0) begin
      failures++;
      $display("FAIL t3_err_clear: got err_illegal=%b, need 0", err_illegal);
    end
    for (int i = 0; i < 6; i++) expect_tuple(t[i], a);
    for (int i = 0; i < TB_DEPTH; i++) send_tuple(t[i]);
    drive_fields(t[TB_DEPTH]);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || mem_wdata !== exp_data[0] || mem_addr !== 32'h200) stall_ok = 0;
      step();
    end
    checks++;
    if (stall_ok != 1) begin
      failures++;
      $display("FAIL t3_stall: got in_ready=%b head=%h, need in_ready=0 head=%h",
               in_ready, mem_wdata, exp_data[0]);
    end
    mem_ready_man = 1'b1;
    for (int i = TB_DEPTH; i < 6; i++) send_tuple(t[i]);
    wait_done("t3");
    check_writes("t3");
  endtask

  task automatic test_overflow();
    logic [31:0] a = 32'h300;
    tup_t t;
    bool_drained: begin end
    mem_ready_man = 1'b1;
    start_session(32'h300);
    for (int i = 0; i < TB_MAX; i++) begin
      t = rand_tup(1'b0, 1'b0);
      expect_tuple(t, a);
      send_tuple(t);
    end
    drive_fields(rand_tup(1'b0, 1'b1));
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL t4_ready: got in_ready=%b, need 0", in_ready);
      end
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (err_overflow !== 1'b1 || busy !== 1'b1 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL t4_ovf: got ovf=%b busy=%b we=%b, need 1/1/0", err_overflow, busy, mem_we);
    end
    step();
    check_writes("t4");
    do_reset();
    checks++;
    if (busy !== 1'b0 || err_overflow !== 1'b0) begin
      failures++;
      $display("FAIL t4_recover: got busy=%b ovf=%b, need 0/0", busy, err_overflow);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] a = 32'hFFFFFFFC;
    tup_t t;
    mem_ready_man = 1'b1;
    start_session(32'hFFFFFFFF);
    for (int i = 0; i < 2; i++) begin
      t = rand_tup(1'b0, i == 1);
      expect_tuple(t, a);
      send_tuple(t);
    end
    wait_done("t5");
    check_writes("t5");
  endtask

  task automatic test_reset_mid();
    logic [31:0] a = 32'h40;
    tup_t t;
    mem_ready_man = 1'b0;
    start_session(32'h500);
    for (int i = 0; i < 3; i++) send_tuple(rand_tup(1'b0, 1'b0));
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL t6_async: got we=%b busy=%b rdy=%b, need 0/0/0", mem_we, busy, in_ready);
    end
    step();
    rst_n = 1'b1;
    mem_ready_man = 1'b1;
    step();
    start_session(32'h40);
    for (int i = 0; i < 2; i++) begin
      t = rand_tup(1'b0, i == 1);
      expect_tuple(t, a);
      send_tuple(t);
    end
    wait_done("t6");
    check_writes("t6");
  endtask

  // Random sessions with random memory stalls, illegal ops and a stray start.
  task automatic test_random();
    logic [31:0] base, a;
    int n;
    bit any_ill;
    tup_t t;
    rnd_mode = 1'b1;
    for (int s = 0; s < 12; s++) begin
      base = $urandom;
      a = base & 32'hFFFFFFFC;
      n = $urandom_range(1, TB_MAX);
      any_ill = 1'b0;
      start_session(base);
      for (int i = 0; i < n; i++) begin
        t = rand_tup(1'b1, i == n - 1);
        if (t.op == 2'd3) any_ill = 1'b1;
        expect_tuple(t, a);
        send_tuple(t);
        if (i == 0 && n > 1) start_session(~base);
      end
      wait_done("rnd");
      check_writes("rnd");
      checks++;
      if (err_illegal !== any_ill || err_overflow !== 1'b0) begin
        failures++;
        $display("FAIL rnd_err: got ill=%b ovf=%b, need %b/0", err_illegal, err_overflow, any_ill);
      end
    end
    rnd_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_branch_illegal();
    test_backpressure();
    test_overflow();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
